// File: rtl/me_pixel_feeder.sv
// me_pixel_feeder
// Sequencer for the full-search motion-estimation PE array: loads the current
// macroblock into the CPR registers, streams the search window into the SPR
// registers (row slices shifted down, then column slices shifted left) and
// flags every completed candidate position with its (x,y) offset.
// Optional feature macro: ME_FEEDER_STALL_EN (honour the stall input, with a
// skid register holding the in-flight read beat). Without it, stall is ignored.
module me_pixel_feeder #(
   parameter int MACRO_DIM  = 16,
   parameter int SEARCH_DIM = 48
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         start,
   input  logic                                         stall,
   output logic                                         busy,
   output logic                                         done,
   output logic                                         cur_rd_en,
   output logic [$clog2(MACRO_DIM)-1:0]                 cur_rd_row,
   input  logic [8*MACRO_DIM-1:0]                       cur_rd_data,
   output logic                                         sw_rd_en,
   output logic                                         sw_rd_dir,
   output logic [$clog2(SEARCH_DIM)-1:0]                sw_rd_x,
   output logic [$clog2(SEARCH_DIM)-1:0]                sw_rd_y,
   input  logic [8*MACRO_DIM-1:0]                       sw_rd_data,
   output logic                                         en_cpr,
   output logic                                         en_spr,
   output logic [1:0]                                   sel,
   output logic [8*MACRO_DIM-1:0]                       pixel_cpr_in,
   output logic [8*MACRO_DIM-1:0]                       pixel_spr_in,
   output logic [8*MACRO_DIM-1:0]                       pixel_spr_right_in,
   output logic                                         cand_valid,
   output logic [$clog2(SEARCH_DIM-MACRO_DIM+1)-1:0]    cand_x,
   output logic [$clog2(SEARCH_DIM-MACRO_DIM+1)-1:0]    cand_y
);

   localparam int NC = SEARCH_DIM - MACRO_DIM + 1;
   localparam int RW = $clog2(MACRO_DIM);
   localparam int SW = $clog2(SEARCH_DIM);
   localparam int CW = $clog2(NC);
   localparam int PW = 8 * MACRO_DIM;

   // Step k within one candidate row: 0..MACRO_DIM-1 are row slices,
   // MACRO_DIM..SEARCH_DIM-1 are column slices (column index == k).
   localparam logic [RW-1:0] R_LAST  = RW'(MACRO_DIM - 1);
   localparam logic [SW-1:0] K_LAST  = SW'(SEARCH_DIM - 1);
   localparam logic [SW-1:0] K_COL0  = SW'(MACRO_DIM);
   localparam logic [SW-1:0] K_CAND0 = SW'(MACRO_DIM - 1);
   localparam logic [CW-1:0] Y_LAST  = CW'(NC - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LOAD_CUR = 2'd1,
      SCAN     = 2'd2,
      DRAIN    = 2'd3
   } state_t;

   // Sequencer state and registered read-issue outputs
   state_t          state_reg;
   logic            busy_reg;
   logic            done_reg;
   logic            cur_rd_en_reg;
   logic [RW-1:0]   cur_rd_row_reg;
   logic            sw_rd_en_reg;
   logic            sw_rd_dir_reg;
   logic [SW-1:0]   sw_rd_x_reg;
   logic [SW-1:0]   sw_rd_y_reg;
   logic [SW-1:0]   k_reg;
   logic [CW-1:0]   y_reg;

   // Return stage: describes the beat whose data arrives this cycle
   logic            ret_cpr_reg;
   logic            ret_spr_reg;
   logic            ret_col_reg;
   logic            ret_cand_reg;
   logic [CW-1:0]   ret_cx_reg;
   logic [CW-1:0]   ret_cy_reg;

   // Candidate stage: array holds a complete candidate this cycle
   logic            cand_valid_reg;
   logic [CW-1:0]   cand_x_reg;
   logic [CW-1:0]   cand_y_reg;

   logic            halt;
   logic [PW-1:0]   live_data;
   logic [PW-1:0]   ret_data;

   // Next scan position and the slice origin it maps to
   logic [SW-1:0]   adv_k;
   logic [CW-1:0]   adv_y;
   logic            adv_col;
   logic [SW-1:0]   adv_x_o;
   logic [SW-1:0]   adv_y_o;
   logic            scan_last;
   logic            iss_cand;
   logic [CW-1:0]   iss_cx;

   // Compute the scan position following the one issued now (origin when entering SCAN)
   always_comb begin
      adv_k = '0;
      adv_y = '0;
      if (state_reg == SCAN) begin
         if (k_reg == K_LAST) begin
            adv_k = '0;
            adv_y = y_reg + 1'b1;
         end else begin
            adv_k = k_reg + 1'b1;
            adv_y = y_reg;
         end
      end
      adv_col   = (adv_k >= K_COL0);
      adv_x_o   = adv_col ? adv_k : '0;
      adv_y_o   = adv_col ? SW'(adv_y) : SW'(adv_y) + adv_k;
      scan_last = (y_reg == Y_LAST) && (k_reg == K_LAST);
      // The last row slice and every column slice complete a candidate
      iss_cand  = (k_reg >= K_CAND0);
      iss_cx    = (k_reg >= K_COL0) ? CW'(k_reg - K_CAND0) : '0;
   end

   // Main FSM: IDLE -> LOAD_CUR -> SCAN -> DRAIN -> IDLE, frozen while halted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
         cur_rd_en_reg  <= 1'b0;
         cur_rd_row_reg <= '0;
         sw_rd_en_reg   <= 1'b0;
         sw_rd_dir_reg  <= 1'b0;
         sw_rd_x_reg    <= '0;
         sw_rd_y_reg    <= '0;
         k_reg          <= '0;
         y_reg          <= '0;
      end else if (!halt) begin
         case (state_reg)
            IDLE: begin
               done_reg <= 1'b0;
               if (start) begin
                  state_reg      <= LOAD_CUR;
                  busy_reg       <= 1'b1;
                  cur_rd_en_reg  <= 1'b1;
                  cur_rd_row_reg <= '0;
               end
            end
            LOAD_CUR: begin
               if (cur_rd_row_reg == R_LAST) begin
                  cur_rd_en_reg <= 1'b0;
                  state_reg     <= SCAN;
                  sw_rd_en_reg  <= 1'b1;
                  sw_rd_dir_reg <= adv_col;
                  sw_rd_x_reg   <= adv_x_o;
                  sw_rd_y_reg   <= adv_y_o;
                  k_reg         <= adv_k;
                  y_reg         <= adv_y;
               end else begin
                  cur_rd_row_reg <= cur_rd_row_reg + 1'b1;
               end
            end
            SCAN: begin
               // One idle SCAN cycle after the final read lets its shift land
               if (!sw_rd_en_reg) begin
                  state_reg <= DRAIN;
               end else if (scan_last) begin
                  sw_rd_en_reg <= 1'b0;
               end else begin
                  sw_rd_dir_reg <= adv_col;
                  sw_rd_x_reg   <= adv_x_o;
                  sw_rd_y_reg   <= adv_y_o;
                  k_reg         <= adv_k;
                  y_reg         <= adv_y;
               end
            end
            DRAIN: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b1;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Return stage: tag the beat that comes back one cycle after issue
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ret_cpr_reg  <= 1'b0;
         ret_spr_reg  <= 1'b0;
         ret_col_reg  <= 1'b0;
         ret_cand_reg <= 1'b0;
         ret_cx_reg   <= '0;
         ret_cy_reg   <= '0;
      end else if (!halt) begin
         ret_cpr_reg  <= cur_rd_en_reg;
         ret_spr_reg  <= sw_rd_en_reg;
         ret_col_reg  <= sw_rd_dir_reg;
         ret_cand_reg <= sw_rd_en_reg & iss_cand;
         ret_cx_reg   <= iss_cx;
         ret_cy_reg   <= y_reg;
      end
   end

   // Candidate stage: strobe the cycle after the completing shift
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cand_valid_reg <= 1'b0;
         cand_x_reg     <= '0;
         cand_y_reg     <= '0;
      end else if (!halt) begin
         cand_valid_reg <= ret_spr_reg & ret_cand_reg;
         cand_x_reg     <= ret_cx_reg;
         cand_y_reg     <= ret_cy_reg;
      end
   end

   assign live_data = ret_cpr_reg ? cur_rd_data : sw_rd_data;

`ifdef ME_FEEDER_STALL_EN
   logic            skid_valid_reg;
   logic [PW-1:0]   skid_data_reg;

   assign halt = stall;

   // Catch the returning beat on the first stalled cycle and replay it on resume
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skid_valid_reg <= 1'b0;
         skid_data_reg  <= '0;
      end else if (halt) begin
         if (!skid_valid_reg) begin
            skid_data_reg <= live_data;
         end
         skid_valid_reg <= 1'b1;
      end else begin
         skid_valid_reg <= 1'b0;
      end
   end

   assign ret_data = skid_valid_reg ? skid_data_reg : live_data;
`else
   logic unused_stall;

   assign halt         = 1'b0;
   assign unused_stall = stall;
   assign ret_data     = live_data;
`endif

   assign busy       = busy_reg;
   assign done       = done_reg & ~halt;
   assign cur_rd_en  = cur_rd_en_reg & ~halt;
   assign cur_rd_row = cur_rd_row_reg;
   assign sw_rd_en   = sw_rd_en_reg & ~halt;
   assign sw_rd_dir  = sw_rd_dir_reg;
   assign sw_rd_x    = sw_rd_x_reg;
   assign sw_rd_y    = sw_rd_y_reg;
   assign en_cpr     = ret_cpr_reg & ~halt;
   assign en_spr     = ret_spr_reg & ~halt;
   assign sel        = en_spr ? (ret_col_reg ? 2'b01 : 2'b00) : 2'b10;
   assign cand_valid = cand_valid_reg & ~halt;
   assign cand_x     = cand_x_reg;
   assign cand_y     = cand_y_reg;

   // Route returned pixels lane by lane; buses not being loaded stay at 0
   genvar gi;
   generate
      for (gi = 0; gi < MACRO_DIM; gi++) begin : g_lane
         assign pixel_cpr_in[8*gi +: 8]       = en_cpr ? ret_data[8*gi +: 8] : 8'd0;
         assign pixel_spr_in[8*gi +: 8]       = (en_spr && !ret_col_reg) ? ret_data[8*gi +: 8] : 8'd0;
         assign pixel_spr_right_in[8*gi +: 8] = (en_spr && ret_col_reg) ? ret_data[8*gi +: 8] : 8'd0;
      end
   endgenerate

endmodule

// File: tb/tb_me_pixel_feeder.sv
// tb_me_pixel_feeder
// Directed bench for me_pixel_feeder: sync-read memories for the current MB and
// the search window, a reference model of the CPR/SPR arrays, and checks of
// timing, candidate order and array contents. Stall run only with ME_FEEDER_STALL_EN.
module tb_me_pixel_feeder;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         stall = 1'b0;
   logic         busy, done, cur_rd_en, sw_rd_en, sw_rd_dir;
   logic [3:0]   cur_rd_row;
   logic [5:0]   sw_rd_x, sw_rd_y;
   logic [127:0] cur_rd_data = '0;
   logic [127:0] sw_rd_data = '0;
   logic         en_cpr, en_spr, cand_valid;
   logic [1:0]   sel;
   logic [127:0] pixel_cpr_in, pixel_spr_in, pixel_spr_right_in;
   logic [5:0]   cand_x, cand_y;

   int errors = 0;
   int checks = 0;

   logic [7:0] spr_m [0:15][0:15];
   logic [7:0] cpr_m [0:15][0:15];
   int cpr_n, strobes, first_cand, done_rel, ex, ey;

   me_pixel_feeder dut (
      .clk(clk), .rst(rst), .start(start), .stall(stall),
      .busy(busy), .done(done),
      .cur_rd_en(cur_rd_en), .cur_rd_row(cur_rd_row), .cur_rd_data(cur_rd_data),
      .sw_rd_en(sw_rd_en), .sw_rd_dir(sw_rd_dir), .sw_rd_x(sw_rd_x), .sw_rd_y(sw_rd_y),
      .sw_rd_data(sw_rd_data),
      .en_cpr(en_cpr), .en_spr(en_spr), .sel(sel),
      .pixel_cpr_in(pixel_cpr_in), .pixel_spr_in(pixel_spr_in),
      .pixel_spr_right_in(pixel_spr_right_in),
      .cand_valid(cand_valid), .cand_x(cand_x), .cand_y(cand_y)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] win(input int r, input int c);
      return 8'(8 * r + c);
   endfunction

   function automatic logic [7:0] cur_px(input int r, input int c);
      return 8'(r * 16 + c * 3 + 7);
   endfunction

   // Sync-read memories, latency one
   always @(posedge clk) begin
      if (cur_rd_en)
         for (int i = 0; i < 16; i++) cur_rd_data[8*i +: 8] <= cur_px(int'(cur_rd_row), i);
      if (sw_rd_en)
         for (int i = 0; i < 16; i++)
            sw_rd_data[8*i +: 8] <= sw_rd_dir ? win(int'(sw_rd_y) + i, int'(sw_rd_x))
                                              : win(int'(sw_rd_y), int'(sw_rd_x) + i);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_ctl"}, 64'({busy, done, cur_rd_en, cur_rd_row, sw_rd_en, sw_rd_dir, sw_rd_x,
                              sw_rd_y, en_cpr, en_spr, cand_valid, cand_x, cand_y}), 64'(0));
      chk({tag, "_sel"}, 64'(sel), 64'(2));
      chk({tag, "_px"}, 64'(|{pixel_cpr_in, pixel_spr_in, pixel_spr_right_in}), 64'(0));
   endtask

   // One operation from start (issued in the current cycle) to done or reset
   task automatic go(input string tag, input int xs1, input int xs2, input int rst_rel,
                     input int st1, input int len1, input int st2, input int len2,
                     input int next_start, input int exp_done, input bit chk_tim);
      int rel;
      int bad;
      bit fin;
      strobes = 0; first_cand = -1; done_rel = -1; ex = 0; ey = 0; cpr_n = 0;
      start = 1'b1;
      rel = 0;
      fin = 1'b0;
      while (!fin) begin
         @(posedge clk); #1;
         rel++;
         start = (rel == xs1) || (rel == xs2) || (rel == next_start);
         rst   = (rel == rst_rel);
         stall = (rel >= st1 && rel < st1 + len1) || (rel >= st2 && rel < st2 + len2);
         @(negedge clk);
         if (chk_tim && rel <= 20) begin
            chk("cur_rd_en", 64'(cur_rd_en), 64'(rel >= 1 && rel <= 16));
            if (rel <= 16) chk("cur_rd_row", 64'(cur_rd_row), 64'(rel - 1));
            chk("en_cpr", 64'(en_cpr), 64'(rel >= 2 && rel <= 17));
            chk("sw_rd_en", 64'(sw_rd_en), 64'(rel >= 17));
            chk("busy", 64'(busy), 64'(1));
         end
         if (stall) chk("stall_quiet", 64'({en_cpr, en_spr, cand_valid, sel}), 64'(5'b00010));
         if (rel == rst_rel || rel == rst_rel + 1) chk_idle_outputs("rst_mid");
         if (cand_valid) begin
            if (first_cand < 0) begin
               first_cand = rel;
               chk("cpr_rows", 64'(cpr_n), 64'(16));
               bad = 0;
               for (int r = 0; r < 16; r++)
                  for (int c = 0; c < 16; c++)
                     if (cpr_m[r][c] !== cur_px(r, c)) bad++;
               chk("cpr_data", 64'(bad), 64'(0));
            end
            chk("cand_x", 64'(cand_x), 64'(ex));
            chk("cand_y", 64'(cand_y), 64'(ey));
            bad = 0;
            for (int r = 0; r < 16; r++)
               for (int c = 0; c < 16; c++)
                  if (spr_m[r][c] !== win(ey + r, ex + c)) bad++;
            chk("spr_window", 64'(bad), 64'(0));
            strobes++;
            if (ex == 32) begin ex = 0; ey++; end else ex++;
         end
         if (en_cpr) begin
            for (int c = 0; c < 16; c++) cpr_m[cpr_n % 16][c] = pixel_cpr_in[8*c +: 8];
            cpr_n++;
         end
         if (en_spr) begin
            if (sel == 2'b00) begin
               for (int r = 0; r < 15; r++)
                  for (int c = 0; c < 16; c++) spr_m[r][c] = spr_m[r+1][c];
               for (int c = 0; c < 16; c++) spr_m[15][c] = pixel_spr_in[8*c +: 8];
            end else begin
               chk("sel_left", 64'(sel), 64'(1));
               chk("spr_in_zero", 64'(|pixel_spr_in), 64'(0));
               for (int r = 0; r < 16; r++) begin
                  for (int c = 0; c < 15; c++) spr_m[r][c] = spr_m[r][c+1];
                  spr_m[r][15] = pixel_spr_right_in[8*r +: 8];
               end
            end
         end
         if (done) begin
            done_rel = rel;
            chk("busy_at_done", 64'(busy), 64'(0));
            fin = 1'b1;
         end
         if (rst_rel > 0 && rel == rst_rel + 1) fin = 1'b1;
         if (rel >= 2500) begin
            chk("timeout", 64'(0), 64'(1));
            fin = 1'b1;
         end
      end
      if (rst_rel > 0) begin
         chk("rst_strobes", 64'(strobes), 64'(462));
      end else begin
         chk("first_cand", 64'(first_cand), 64'(34));
         chk("done_cycle", 64'(done_rel), 64'(exp_done));
         chk("strobes", 64'(strobes), 64'(1089));
      end
      $display("run %s: strobes=%0d first_cand=%0d done=%0d", tag, strobes, first_cand, done_rel);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk_idle_outputs("reset");
      rst = 1'b0;
      @(posedge clk); #1;
      chk_idle_outputs("idle");
      // Starts while busy at 5 and 500; next run starts on the done cycle
      go("busy_starts", 5, 500, -1, -1, 0, -1, 0, 1603, 1603, 1'b1);
      go("back_to_back", -1, -1, -1, -1, 0, -1, 0, -1, 1603, 1'b1);
      go("reset_700", -1, -1, 700, -1, 0, -1, 0, -1, 0, 1'b0);
      go("after_reset", -1, -1, -1, -1, 0, -1, 0, -1, 1603, 1'b1);
`ifdef ME_FEEDER_STALL_EN
      go("stall", -1, -1, -1, 40, 5, 1000, 3, -1, 1611, 1'b0);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
